// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin burst arbiter streaming contiguous words from one shared synchronous-read ROM
module rom_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 10,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(REQUESTERS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [REQUESTERS-1:0]          request,
  input  logic [REQUESTERS-1:0][AW-1:0]  base_address,
  input  logic [REQUESTERS-1:0][LW-1:0]  length,
  output logic [REQUESTERS-1:0]          grant,
  output logic [AW-1:0]                  rom_address,
  input  logic [WIDTH-1:0]               rom_data,
  output logic [REQUESTERS-1:0]          response_valid,
  output logic                           response_last,
  output logic [WIDTH-1:0]               response_data
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state;
  logic [PW-1:0] pointer, owner, winner;
  logic [AW-1:0] address;
  logic [LW-1:0] remaining, eff;
  logic idle, found, issue, last;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] a);
    return a == AW'(DEPTH - 1) ? '0 : a + AW'(1);
  endfunction
  // lowest requesting index at or above the pointer wins, else lowest overall
  always_comb begin
    winner = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--) if (request[i]) winner = PW'(i);
    for (int i = REQUESTERS - 1; i >= 0; i--) if (request[i] && PW'(i) >= pointer) winner = PW'(i);
  end
  assign idle = state == IDLE;
  assign found = |request;
  assign eff = length[winner] == '0 ? LW'(1) : length[winner];
  assign issue = !idle || found;
  assign last = idle ? eff == LW'(1) : remaining == LW'(1);
  assign grant = (!reset && idle && found) ? REQUESTERS'(1) << winner : '0;
  assign rom_address = reset ? '0 : !idle ? address : found ? base_address[winner] : '0;
  assign response_data = rom_data;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      pointer <= '0;
      owner <= '0;
      address <= '0;
      remaining <= '0;
      response_valid <= '0;
      response_last <= 1'b0;
    end else begin
      response_valid <= issue ? REQUESTERS'(1) << (idle ? winner : owner) : '0;
      response_last <= issue && last;
      if (idle && found) begin
        state <= eff == LW'(1) ? IDLE : BURST;
        pointer <= winner == PW'(REQUESTERS - 1) ? '0 : winner + PW'(1);
        owner <= winner;
        address <= inc(base_address[winner]);
        remaining <= eff - LW'(1);
      end else if (!idle) begin
        state <= last ? IDLE : BURST;
        address <= inc(address);
        remaining <= remaining - LW'(1);
      end
    end
endmodule
